// File: rtl/ctrl_stack_if.sv
// ctrl_stack_if: request/response bus between the decode stage and ctrl_stack.
//   master (decode): drives op_valid, op, push_*, br_depth; sees op_ready, out_*.
//   slave  (stack) : the reverse.
// Signals:
//   op_valid/op_ready  request handshake (ready drops permanently on a trap)
//   op                 0 NOP, 1 PUSH, 2 END, 3 BR, 5 ELSE
//   push_kind/type/empty/cont/sp  frame contents for PUSH
//   br_depth           relative label index for BR
//   out_valid          one-cycle pulse with resolved jump in out_target/sp/type/empty
interface ctrl_stack_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 6,
  parameter int SP_W   = 8
);
  localparam int BD_W = $clog2(DEPTH);

  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op;
  logic [1:0]        push_kind;
  logic [1:0]        push_type;
  logic              push_empty;
  logic [ADDR_W-1:0] push_cont;
  logic [SP_W-1:0]   push_sp;
  logic [BD_W-1:0]   br_depth;

  logic              out_valid;
  logic [ADDR_W-1:0] out_target;
  logic [SP_W-1:0]   out_sp;
  logic [1:0]        out_type;
  logic              out_empty;

  modport master (
    output op_valid, op, push_kind, push_type, push_empty, push_cont, push_sp, br_depth,
    input  op_ready, out_valid, out_target, out_sp, out_type, out_empty
  );

  modport slave (
    input  op_valid, op, push_kind, push_type, push_empty, push_cont, push_sp, br_depth,
    output op_ready, out_valid, out_target, out_sp, out_type, out_empty
  );
endinterface

// File: rtl/ctrl_stack.sv
// ctrl_stack: WebAssembly control-frame stack. One frame per open
// block/loop/if; END, BR N and ELSE resolve to a continuation address,
// operand-stack height and result signature, reported one cycle later.
//
// Ports:
//   clk, reset    single clock, synchronous active-high reset
//   bus (slave)   request/response handshake, see ctrl_stack_if
//   count         number of open frames
//   empty, full   count==0 / count==DEPTH
//   trap          0 none, 1 overflow, 2 underflow, 3 bad depth,
//                 4 else-without-if, 5 illegal op (sticky until reset)
//
// Build option: define CTRL_STACK_ELSE_EN to support ELSE. Without it, ELSE
// is an illegal op and if-frames behave exactly like block frames.
module ctrl_stack #(
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = 6,
  parameter  int SP_W   = 8,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_stack_if.slave      bus,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic [3:0]       trap
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_END  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_ELSE = 3'd5;

  localparam logic [1:0] K_LOOP = 2'd1;
  localparam logic [1:0] K_IF   = 2'd2;
  localparam logic [1:0] K_ELSE = 2'd3; // if-frame already in its else-part

  localparam logic [3:0] T_NONE  = 4'd0;
  localparam logic [3:0] T_OVF   = 4'd1;
  localparam logic [3:0] T_UNF   = 4'd2;
  localparam logic [3:0] T_DEPTH = 4'd3;
  localparam logic [3:0] T_ELSE  = 4'd4;
  localparam logic [3:0] T_ILL   = 4'd5;

  // frame storage
  logic [1:0]        kind_q  [DEPTH];
  logic [1:0]        type_q  [DEPTH];
  logic              fempty_q[DEPTH];
  logic [ADDR_W-1:0] cont_q  [DEPTH];
  logic [SP_W-1:0]   sp_q    [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        trap_q, trap_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [SP_W-1:0]   osp_q, osp_d;
  logic [1:0]        otype_q, otype_d;
  logic              oempty_q, oempty_d;

  logic              acc;
  logic              wr_en;
  logic              else_set;
  logic              is_full;
  logic              is_empty;
  logic [CNT_W-1:0]  top_w;
  logic [IDX_W-1:0]  top_idx;
  logic [CNT_W-1:0]  br_w;
  logic [IDX_W-1:0]  br_idx;
  logic              br_bad;
  logic              br_loop;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);
  assign acc      = bus.op_valid && (trap_q == T_NONE);

  assign top_w   = count_q - CNT_W'(1);
  assign top_idx = top_w[IDX_W-1:0];

  // Target frame for BR is count-1-N, computed one bit wider than an index
  // so that N >= count is caught by the compare instead of wrapping.
  assign br_w    = count_q - CNT_W'(1) - CNT_W'(bus.br_depth);
  assign br_idx  = br_w[IDX_W-1:0];
  assign br_bad  = (CNT_W'(bus.br_depth) >= count_q);
  assign br_loop = (kind_q[br_idx] == K_LOOP);

  always_comb begin
    count_d  = count_q;
    trap_d   = trap_q;
    vld_d    = 1'b0;
    tgt_d    = tgt_q;
    osp_d    = osp_q;
    otype_d  = otype_q;
    oempty_d = oempty_q;
    wr_en    = 1'b0;
    else_set = 1'b0;
    if (acc) begin
      case (bus.op)
        OP_NOP: ;
        OP_PUSH: begin
          // kind 3 is internal state only; pushing it directly is malformed
          if (is_full)                    trap_d = T_OVF;
          else if (bus.push_kind == K_ELSE) trap_d = T_ILL;
          else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        OP_END: begin
          if (is_empty) trap_d = T_UNF;
          else begin
            vld_d    = 1'b1;
            tgt_d    = cont_q[top_idx];
            osp_d    = sp_q[top_idx];
            otype_d  = type_q[top_idx];
            oempty_d = fempty_q[top_idx];
            count_d  = top_w;
          end
        end
        OP_BR: begin
          if (br_bad) trap_d = T_DEPTH;
          else begin
            vld_d   = 1'b1;
            tgt_d   = cont_q[br_idx];
            osp_d   = sp_q[br_idx];
            otype_d = type_q[br_idx];
            // branching to a loop re-enters it: keep the frame, carry no value
            oempty_d = br_loop ? 1'b1 : fempty_q[br_idx];
            count_d  = br_loop ? (br_w + CNT_W'(1)) : br_w;
          end
        end
`ifdef CTRL_STACK_ELSE_EN
        OP_ELSE: begin
          if (!is_empty && kind_q[top_idx] == K_IF) begin
            // then-part finished: jump past the matching end, frame stays open
            vld_d    = 1'b1;
            tgt_d    = cont_q[top_idx];
            osp_d    = sp_q[top_idx];
            otype_d  = type_q[top_idx];
            oempty_d = fempty_q[top_idx];
            else_set = 1'b1;
          end else begin
            trap_d = T_ELSE;
          end
        end
`endif
        default: trap_d = T_ILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      trap_q   <= T_NONE;
      vld_q    <= 1'b0;
      tgt_q    <= '0;
      osp_q    <= '0;
      otype_q  <= '0;
      oempty_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      trap_q   <= trap_d;
      vld_q    <= vld_d;
      tgt_q    <= tgt_d;
      osp_q    <= osp_d;
      otype_q  <= otype_d;
      oempty_q <= oempty_d;
    end
  end

  // Frame contents need no reset: count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      kind_q  [count_q[IDX_W-1:0]] <= bus.push_kind;
      type_q  [count_q[IDX_W-1:0]] <= bus.push_type;
      fempty_q[count_q[IDX_W-1:0]] <= bus.push_empty;
      cont_q  [count_q[IDX_W-1:0]] <= bus.push_cont;
      sp_q    [count_q[IDX_W-1:0]] <= bus.push_sp;
    end
    if (!reset && else_set) kind_q[top_idx] <= K_ELSE;
  end

  assign bus.op_ready   = (trap_q == T_NONE);
  assign bus.out_valid  = vld_q;
  assign bus.out_target = tgt_q;
  assign bus.out_sp     = osp_q;
  assign bus.out_type   = otype_q;
  assign bus.out_empty  = oempty_q;
  assign count          = count_q;
  assign empty          = is_empty;
  assign full           = is_full;
  assign trap           = trap_q;

endmodule

// File: tb/tb_ctrl_stack.sv
module tb_ctrl_stack;
  localparam int DEPTH = 16, ADDR_W = 6, SP_W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] count;
  logic       empty, full;
  logic [3:0] trap;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  ctrl_stack_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SP_W(SP_W)) bus ();

  ctrl_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SP_W(SP_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .count(count), .empty(empty), .full(full), .trap(trap)
  );

  typedef struct {
    logic [2:0] op;
    logic [1:0] kind;
    logic [1:0] typ;
    logic       emp;
    logic [5:0] cont;
    logic [7:0] sp;
    logic [3:0] dep;
    logic       e_valid;
    logic       chk_out;
    logic [5:0] e_target;
    logic [7:0] e_sp;
    logic [1:0] e_type;
    logic       e_empty;
    logic [4:0] e_count;
    logic [3:0] e_trap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] op, logic [1:0] kind, logic [1:0] typ, logic emp,
                              logic [5:0] cont, logic [7:0] sp, logic [3:0] dep,
                              logic e_valid, logic chk_out, logic [5:0] e_target,
                              logic [7:0] e_sp, logic [1:0] e_type, logic e_empty,
                              logic [4:0] e_count, logic [3:0] e_trap);
    vec_t v;
    v.op = op; v.kind = kind; v.typ = typ; v.emp = emp; v.cont = cont; v.sp = sp;
    v.dep = dep; v.e_valid = e_valid; v.chk_out = chk_out; v.e_target = e_target;
    v.e_sp = e_sp; v.e_type = e_type; v.e_empty = e_empty; v.e_count = e_count;
    v.e_trap = e_trap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one op for one edge, then sample 1ns after the edge
  task automatic op1(input logic [2:0] op, input logic [1:0] kind, input logic [1:0] typ,
                     input logic emp, input logic [5:0] cont, input logic [7:0] sp,
                     input logic [3:0] dep);
    bus.op_valid = 1'b1; bus.op = op; bus.push_kind = kind; bus.push_type = typ;
    bus.push_empty = emp; bus.push_cont = cont; bus.push_sp = sp; bus.br_depth = dep;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op = '0; bus.push_kind = '0; bus.push_type = '0;
    bus.push_empty = 1'b0; bus.push_cont = '0; bus.push_sp = '0; bus.br_depth = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.trap", trap, 0);
    chk("rst.ready", bus.op_ready, 1);
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.target", bus.out_target, 0);
    chk("rst.sp", bus.out_sp, 0);
    chk("rst.type", bus.out_type, 0);
    chk("rst.oempty", bus.out_empty, 0);

    //           op kind typ emp cont  sp  dep  vld chk tgt   sp  ty em cnt trap
    tbl.push_back(mk(1, 0, 1, 0, 6'h20, 3, 0,   0, 0, 0,     0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0,     0, 0,   1, 1, 6'h20, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 6'h30, 1, 0,   0, 0, 0,     0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 6'h08, 2, 0,   0, 0, 0,     0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 2, 3, 0, 6'h18, 2, 0,   0, 0, 0,     0, 0, 0, 3, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0,     0, 1,   1, 1, 6'h08, 2, 0, 1, 2, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0,     0, 1,   1, 1, 6'h30, 1, 2, 0, 0, 0));
    // NOP: outputs hold the last jump
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0,   0, 1, 6'h30, 1, 2, 0, 0, 0));
    // rebuild and branch to the if-frame (acts as block) then to the loop
    tbl.push_back(mk(1, 0, 2, 1, 6'h3F, 9, 0,   0, 0, 0,     0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 6'h04, 5, 0,   0, 0, 0,     0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 2, 3, 0, 6'h12, 7, 0,   0, 0, 0,     0, 0, 0, 3, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0,     0, 0,   1, 1, 6'h12, 7, 3, 0, 2, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0,     0, 0,   1, 1, 6'h04, 5, 1, 1, 2, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0,     0, 0,   1, 1, 6'h04, 5, 1, 0, 1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0,     0, 0,   1, 1, 6'h3F, 9, 2, 1, 0, 0));
    // END on empty stack: underflow, no pulse
    tbl.push_back(mk(2, 0, 0, 0, 0,     0, 0,   0, 0, 0,     0, 0, 0, 0, 2));

    for (int r = 0; r < tbl.size(); r++) begin
      op1(tbl[r].op, tbl[r].kind, tbl[r].typ, tbl[r].emp, tbl[r].cont, tbl[r].sp, tbl[r].dep);
      chk($sformatf("row%0d.valid", r), bus.out_valid, tbl[r].e_valid);
      chk($sformatf("row%0d.count", r), count, tbl[r].e_count);
      chk($sformatf("row%0d.trap", r), trap, tbl[r].e_trap);
      if (tbl[r].chk_out) begin
        chk($sformatf("row%0d.target", r), bus.out_target, tbl[r].e_target);
        chk($sformatf("row%0d.sp", r), bus.out_sp, tbl[r].e_sp);
        chk($sformatf("row%0d.type", r), bus.out_type, tbl[r].e_type);
        chk($sformatf("row%0d.oempty", r), bus.out_empty, tbl[r].e_empty);
      end
    end
    chk("unf.ready", bus.op_ready, 0);

    // BR 3 with two frames open: bad depth, state untouched, sticky
    do_reset();
    op1(1, 0, 0, 0, 6'h01, 1, 0);
    op1(1, 0, 0, 0, 6'h02, 2, 0);
    op1(3, 0, 0, 0, 0, 0, 3);
    chk("bad.trap", trap, 3);
    chk("bad.valid", bus.out_valid, 0);
    chk("bad.count", count, 2);
    op1(2, 0, 0, 0, 0, 0, 0);
    chk("bad.sticky_valid", bus.out_valid, 0);
    chk("bad.sticky_count", count, 2);
    chk("bad.sticky_trap", trap, 3);

    // fill to DEPTH then overflow
    do_reset();
    for (int k = 0; k < DEPTH; k++) op1(1, 0, 0, 0, 6'(k), 8'(k), 0);
    chk("fill.full", full, 1);
    chk("fill.count", count, 16);
    chk("fill.empty", empty, 0);
    chk("fill.trap0", trap, 0);
    op1(1, 0, 0, 0, 6'h3E, 0, 0);
    chk("ovf.trap", trap, 1);
    chk("ovf.count", count, 16);
    chk("ovf.ready", bus.op_ready, 0);
    chk("ovf.valid", bus.out_valid, 0);
    op1(0, 0, 0, 0, 0, 0, 0);
    chk("ovf.ready_hold", bus.op_ready, 0);

    // ELSE handling
    do_reset();
    op1(1, 2, 3, 1, 6'h2A, 4, 0);
`ifdef CTRL_STACK_ELSE_EN
    op1(5, 0, 0, 0, 0, 0, 0);
    chk("else.valid", bus.out_valid, 1);
    chk("else.target", bus.out_target, 6'h2A);
    chk("else.sp", bus.out_sp, 4);
    chk("else.count", count, 1);
    chk("else.trap", trap, 0);
    op1(5, 0, 0, 0, 0, 0, 0);
    chk("else2.trap", trap, 4);
    chk("else2.valid", bus.out_valid, 0);
`else
    op1(5, 0, 0, 0, 0, 0, 0);
    chk("else.trap", trap, 5);
    chk("else.valid", bus.out_valid, 0);
    chk("else.count", count, 1);
`endif

    // illegal opcode
    do_reset();
    op1(7, 0, 0, 0, 0, 0, 0);
    chk("ill.trap", trap, 5);

    // reset in the cycle after a BR drops everything, including a new op
    do_reset();
    chk("rst2.trap", trap, 0);
    op1(1, 0, 1, 0, 6'h11, 1, 0);
    op1(1, 0, 1, 0, 6'h12, 2, 0);
    op1(1, 0, 1, 0, 6'h13, 3, 0);
    op1(3, 0, 0, 0, 0, 0, 0);
    chk("brr.valid", bus.out_valid, 1);
    chk("brr.count", count, 2);
    reset = 1'b1;
    op1(2, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("brr.rst_valid", bus.out_valid, 0);
    chk("brr.rst_count", count, 0);
    chk("brr.rst_trap", trap, 0);
    chk("brr.rst_target", bus.out_target, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
